// File: rtl/sdr_arb_pkg.sv
// Shared SDRAM timing and command definitions for the sdr_arb scheduler slice.
// Clock counts are derived from the datasheet timings so a speed-grade change stays in one place.
package sdr_arb_pkg;

    localparam int T_CK_PS   = 6000;
    localparam int T_RP_PS   = 18000;
    localparam int T_RFC_PS  = 66000;
    localparam int T_REFI_PS = 7800000;

    function automatic int cdiv(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int NRP_DEF      = cdiv(T_RP_PS, T_CK_PS);
    localparam int NRFC_DEF     = cdiv(T_RFC_PS, T_CK_PS);
    localparam int TREF_CYC_DEF = T_REFI_PS / T_CK_PS;

    // {nRAS, nCAS, nWE}
    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_AREF      = 3'b001;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } grant_e;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] a;
    } sdr_pins_t;

endpackage

// File: rtl/sdr_arb_if.sv
// Engine/client handshake plus SDRAM pin bundle around the command scheduler.
// master = scheduler side, slave = clients, engines and the device pins.
interface sdr_arb_if;
    logic        wr_req, rd_req;
    logic        wr_start, rd_start;
    logic        wr_exit, rd_exit;
    logic        need_ref, ref_overrun;
    logic [2:0]  wr_cmd, rd_cmd;
    logic [1:0]  wr_ba, rd_ba;
    logic [12:0] wr_a, rd_a;
    logic        sdr_CKE, sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE;
    logic [1:0]  sdr_BA;
    logic [12:0] sdr_A;

    modport master (
        input  wr_req, rd_req, wr_exit, rd_exit,
        input  wr_cmd, wr_ba, wr_a, rd_cmd, rd_ba, rd_a,
        output wr_start, rd_start, need_ref, ref_overrun,
        output sdr_CKE, sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE, sdr_BA, sdr_A
    );

    modport slave (
        output wr_req, rd_req, wr_exit, rd_exit,
        output wr_cmd, wr_ba, wr_a, rd_cmd, rd_ba, rd_a,
        input  wr_start, rd_start, need_ref, ref_overrun,
        input  sdr_CKE, sdr_nCS, sdr_nRAS, sdr_nCAS, sdr_nWE, sdr_BA, sdr_A
    );
endinterface

// File: rtl/sdr_ref_timer.sv
// Auto-refresh interval timer: raises need_ref every TREF_CYC enabled clocks,
// flags an overrun when a tick lands on a refresh that is still outstanding.
module sdr_ref_timer
    import sdr_arb_pkg::*;
#(
    parameter int TREF_CYC = TREF_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic need_ref_o,
    output logic ref_overrun_o
);
    logic [10:0] cnt_q, cnt_d;
    logic        need_q, need_d;
    logic        ovr_q, ovr_d;
    logic        tick;

    always_comb begin
        tick   = en_i && (cnt_q == 11'(TREF_CYC - 1));
        cnt_d  = cnt_q;
        need_d = need_q;
        ovr_d  = ovr_q;
        if (en_i) cnt_d = tick ? 11'd0 : cnt_q + 11'd1;
        // A tick landing on the clear cycle wins so that refresh is not lost.
        if (tick) begin
            need_d = 1'b1;
            if (need_q) ovr_d = 1'b1;
        end else if (clr_i) begin
            need_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            need_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            need_q <= need_d;
            ovr_q  <= ovr_d;
        end
    end

    assign need_ref_o    = need_q;
    assign ref_overrun_o = ovr_q;
endmodule

// File: rtl/sdr_arb.sv
// SDRAM command scheduler: runs precharge-all/auto-refresh, grants the command bus
// to the read or write engine in alternation, and muxes the owner onto the pins.
module sdr_arb
    import sdr_arb_pkg::*;
#(
    parameter int TREF_CYC = TREF_CYC_DEF,
    parameter int NRP      = NRP_DEF,
    parameter int NRFC     = NRFC_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      init_done,
    sdr_arb_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_PRE  = 3'd3;
    localparam logic [2:0] S_TRP  = 3'd4;
    localparam logic [2:0] S_AREF = 3'd5;
    localparam logic [2:0] S_TRFC = 3'd6;

    logic [2:0] state_q, state_d;
    grant_e     last_q, last_d;
    logic       wr_start_q, wr_start_d;
    logic       rd_start_q, rd_start_d;
    logic [3:0] wait_q, wait_d;
    logic       need_ref, ref_overrun;
    sdr_pins_t  pins;

    sdr_ref_timer #(.TREF_CYC(TREF_CYC)) u_ref (
        .clk           (clk),
        .rst           (rst),
        .en_i          (init_done),
        .clr_i         (state_d == S_AREF),
        .need_ref_o    (need_ref),
        .ref_overrun_o (ref_overrun)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        wr_start_d = 1'b0;
        rd_start_d = 1'b0;
        wait_d     = wait_q;
        case (state_q)
            S_IDLE: if (init_done) begin
                if (need_ref) begin
                    state_d = S_PRE;
                end else if (bus.wr_req && (!bus.rd_req || last_q == GNT_RD)) begin
                    state_d    = S_WR;
                    wr_start_d = 1'b1;
                    last_d     = GNT_WR;
                end else if (bus.rd_req) begin
                    state_d    = S_RD;
                    rd_start_d = 1'b1;
                    last_d     = GNT_RD;
                end
            end
            S_WR: if (bus.wr_exit) state_d = S_IDLE;
            S_RD: if (bus.rd_exit) state_d = S_IDLE;
            // wait_q counts cycles since the command cycle, which itself is cycle 0.
            S_PRE: begin
                state_d = S_TRP;
                wait_d  = 4'd1;
            end
            S_TRP: begin
                if (wait_q == 4'(NRP - 1)) state_d = S_AREF;
                else                       wait_d  = wait_q + 4'd1;
            end
            S_AREF: begin
                state_d = S_TRFC;
                wait_d  = 4'd1;
            end
            S_TRFC: begin
                if (wait_q == 4'(NRFC - 1)) state_d = S_IDLE;
                else                        wait_d  = wait_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_q     <= GNT_RD;
            wr_start_q <= 1'b0;
            rd_start_q <= 1'b0;
            wait_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wr_start_q <= wr_start_d;
            rd_start_q <= rd_start_d;
            wait_q     <= wait_d;
        end
    end

    // Pass-through adds no register stage so engine DQ timing is unchanged.
    always_comb begin
        pins.cmd = CMD_NOP;
        pins.ba  = 2'b00;
        pins.a   = 13'h0;
        case (state_q)
            S_WR: begin
                pins.cmd = bus.wr_cmd;
                pins.ba  = bus.wr_ba;
                pins.a   = bus.wr_a;
            end
            S_RD: begin
                pins.cmd = bus.rd_cmd;
                pins.ba  = bus.rd_ba;
                pins.a   = bus.rd_a;
            end
            S_PRE: begin
                pins.cmd = CMD_PRECHARGE;
                pins.a   = 13'h400;
            end
            S_AREF: pins.cmd = CMD_AREF;
            default: ;
        endcase
    end

    assign bus.wr_start    = wr_start_q;
    assign bus.rd_start    = rd_start_q;
    assign bus.need_ref    = need_ref;
    assign bus.ref_overrun = ref_overrun;
    assign bus.sdr_CKE     = 1'b1;
    assign bus.sdr_nCS     = 1'b0;
    assign bus.sdr_nRAS    = pins.cmd[2];
    assign bus.sdr_nCAS    = pins.cmd[1];
    assign bus.sdr_nWE     = pins.cmd[0];
    assign bus.sdr_BA      = pins.ba;
    assign bus.sdr_A       = pins.a;
endmodule
